// File: rtl/spell_wb_host.sv
// Wishbone initiator for the spell core: turns valid/ready commands into single
// bus reads/writes, or a RUN write followed by RUN polls until the core sleeps.
module spell_wb_host #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd255,
  parameter logic [7:0]  POLL_GAP  = 8'd4,
  parameter logic [15:0] MAX_POLLS = 16'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS,
    S_GAP,
    S_POLL_WAIT,
    S_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  localparam logic [23:0] RUN_REG = 24'h00_000c;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] polls_q, polls_d;
  logic        polling_q, polling_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [8:0]  timer_inc;
  logic [8:0]  gap_inc;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    polls_d   = polls_q;
    polling_d = polling_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    // 9-bit increments keep the limit compares correct even for limits of 0 or 255
    timer_inc = {1'b0, timer_q} + 9'd1;
    gap_inc   = {1'b0, gap_q} + 9'd1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d      = op_e'(cmd_op);
          err_d     = 1'b0;
          rdata_d   = '0;
          timer_d   = '0;
          gap_d     = '0;
          polls_d   = '0;
          polling_d = 1'b0;
          unique case (op_e'(cmd_op))
            OP_READ, OP_WRITE: begin
              we_d    = (op_e'(cmd_op) == OP_WRITE);
              addr_d  = BASE_ADDR | {8'h00, cmd_addr};
              wdata_d = cmd_data;
              state_d = S_BUS;
            end
            OP_RUN: begin
              we_d    = 1'b1;
              addr_d  = BASE_ADDR | {8'h00, RUN_REG};
              wdata_d = {30'b0, cmd_data[1], 1'b1};
              state_d = S_BUS;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_RESPOND;
            end
          endcase
        end
      end

      S_BUS: begin
        if (i_wb_ack) begin
          timer_d = '0;
          if (!we_q) begin
            rdata_d = i_wb_data;
          end
          state_d = S_GAP;
        end else if (timer_inc >= {1'b0, TIMEOUT}) begin
          timer_d = TIMEOUT;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_inc[7:0];
        end
      end

      // One dead cycle swallows spell's trailing ack before anything else happens
      S_GAP: begin
        if (err_q || (op_q != OP_RUN)) begin
          state_d = S_RESPOND;
        end else if (!polling_q || rdata_q[0]) begin
          gap_d   = '0;
          state_d = S_POLL_WAIT;
        end else begin
          state_d = S_RESPOND;
        end
      end

      S_POLL_WAIT: begin
        if ((MAX_POLLS != 16'd0) && (polls_q == MAX_POLLS)) begin
          err_d   = 1'b1;
          state_d = S_RESPOND;
        end else if (gap_inc >= {1'b0, POLL_GAP}) begin
          gap_d     = '0;
          timer_d   = '0;
          polls_d   = polls_q + 16'd1;
          polling_d = 1'b1;
          we_d      = 1'b0;
          addr_d    = BASE_ADDR | {8'h00, RUN_REG};
          state_d   = S_BUS;
        end else begin
          gap_d = gap_inc[7:0];
        end
      end

      S_RESPOND: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    cyc_d       = (state_d == S_BUS);
    rsp_valid_d = (state_d == S_RESPOND);
    rsp_data_d  = rsp_valid_d ? rdata_d : '0;
    rsp_error_d = rsp_valid_d & err_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      polls_q     <= '0;
      polling_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      polls_q     <= polls_d;
      polling_q   <= polling_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = cyc_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;

endmodule

// File: doc/spell_wb_host.md
Name: spell_wb_host

Overview:
- Wishbone initiator that drives the spell core's Wishbone responder port from a simple valid/ready command interface.
- Used by on-chip test/boot logic to do three things without a CPU:
  - load and inspect spell registers and stack (single reads and writes);
  - start execution and poll the RUN register until the core sleeps (run-and-wait macro).
- Sits between the boot/test controller and spell's i_wb_* / o_wb_* pins.

Parameters:
- BASE_ADDR, 32'h3000_0000, spell's base address; OR'd with the 24-bit command address.
- TIMEOUT, 8'd255, cycles to wait for ack before aborting a bus transaction.
- POLL_GAP, 8'd4, idle cycles between consecutive RUN polls.
- MAX_POLLS, 16'd0, poll limit for run-and-wait; 0 means unlimited.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  host can accept a command
- cmd_op  input  2  0=read, 1=write, 2=run-and-wait, 3=reserved
- cmd_addr  input  24  register offset (e.g. 0x000 PC, 0x00c RUN, 0x100+n stack)
- cmd_data  input  32  write data; for run-and-wait, bit1 = single_step
- rsp_valid  output  1  one-cycle response pulse
- rsp_data  output  32  read data, or final RUN value for run-and-wait
- rsp_error  output  1  valid with rsp_valid; timeout, poll limit, or reserved op
- o_wb_cyc  output  1  Wishbone cycle
- o_wb_stb  output  1  Wishbone strobe
- o_wb_we  output  1  Wishbone write enable
- o_wb_addr  output  32  BASE_ADDR | {8'b0, addr}
- o_wb_data  output  32  Wishbone write data
- i_wb_ack  input  1  responder ack
- i_wb_data  input  32  responder read data

Behaviour:
- Reset (synchronous): state=Idle. All outputs 0 except cmd_ready=1. Timers and poll counter cleared. Any in-flight bus cycle is dropped: cyc/stb low on the cycle after the reset edge.
- States: Idle, Bus, Gap, PollWait, Respond.
- Idle:
  - cmd_ready=1.
  - Accept on the edge where cmd_valid & cmd_ready; latch op, addr and data.
  - read/write: go to Bus.
  - run-and-wait: go to Bus with we=1, addr=0x00c, data={30'b0, cmd_data[1], 1'b1}.
  - op 3: go straight to Respond with rsp_error=1, rsp_data=0.
- Bus:
  - cmd_ready=0. cyc=stb=1, we/addr/data held stable; the ack timer increments every cycle.
  - On the edge sampling i_wb_ack=1: drop cyc/stb, capture i_wb_data for reads, clear the timer, go to Gap.
  - If the timer reaches TIMEOUT without ack: drop cyc/stb, set the error flag, go to Gap.
- Gap:
  - Exactly one cycle with cyc=stb=0. This absorbs the responder's trailing ack, because spell re-acks while stb was sampled high.
  - i_wb_ack is ignored in every state except Bus.
  - Next state:
    - read/write, or any error: Respond.
    - run-and-wait: if the RUN write just finished, or a poll read returned bit0=1, go to PollWait; if the poll read returned bit0=0, go to Respond.
- PollWait:
  - Count POLL_GAP cycles, increment the poll counter, then go to Bus with a read of 0x00c.
  - If MAX_POLLS≠0 and the counter equals MAX_POLLS: go to Respond with rsp_error=1 and rsp_data = last RUN value.
- Respond:
  - rsp_valid=1 for exactly one cycle with rsp_data/rsp_error; return to Idle, where cmd_ready=1 on the next cycle.
  - Write responses return rsp_data=0.
- Latency (plain read/write, responder acks 1 cycle after stb):
  - Edge E0 accepts the command; cyc/stb high after E0.
  - Ack is high after E1 and sampled at E2.
  - Gap is after E2, rsp_valid after E3, cmd_ready after E4.
  - Minimum total: 4 cycles from acceptance to rsp_valid.
- Outputs are all registered. o_wb_addr/o_wb_data/o_wb_we keep their last values outside Bus and are don't-care there.
- Simultaneous cases:
  - Ack on the same edge as the timer reaching TIMEOUT: ack wins, no error.
  - cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the source.
- Width rules:
  - Addresses wrap within 24 bits; no carry into BASE_ADDR.
  - The ack timer saturates at TIMEOUT.
  - The poll counter is 16 bits.

Test Plan:
- Write 0x000 data 0x12 → one bus cycle with o_wb_addr=0x3000_0000, we=1, data=0x12. Bench responder acks 1 cycle later → rsp_valid 4 cycles after accept, rsp_error=0. A following read of 0x000 returns rsp_data=0x12.
- Read stack 0x105 with the responder returning 0xA5 and holding ack 2 cycles (spell behaviour) → exactly one rsp_valid, rsp_data=0xA5; the second ack causes no extra transaction or response.
- Run-and-wait with cmd_data=0. Responder RUN reads return 1 for the first 3 polls, then 0 → one write of 0x1 to 0x3000_000c, then 4 reads each separated by ≥POLL_GAP idle cycles, then rsp_data=0, rsp_error=0.
- Responder never acks → cyc/stb high for exactly 255 cycles, then drop → rsp_valid with rsp_error=1, rsp_data=0; cmd_ready returns to 1.
- MAX_POLLS=2 and RUN stays 1 → 2 poll reads then rsp_error=1, rsp_data=1. cmd_op=3 → rsp_error=1 with no bus activity.
- Reset asserted mid-Bus → cyc/stb/rsp_valid low on the next cycle and cmd_ready=1; a subsequent read completes normally.
